instr_fetch_seq: RTL and testbench

- Instruction fetch/sequencer: the producer side of the control unit's opcode interface.
- Fetches 8-bit instructions from program memory over a request/valid handshake, splits each into opcode and register fields, and presents them to the control unit. The control unit then produces ALUOp and RegWrite from the Opcode.
- Manages the PC, stall hold, the HALT instruction, illegal-opcode detection and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_decode_fields.sv | 25 ++
 rtl/instr_fetch_seq.sv | 115 +++++++++++
 tb/tb_instr_fetch_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer and control unit: opcode map,
// instruction field positions and the sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned RD_MSB  = 3;
  localparam int unsigned RD_LSB  = 2;
  localparam int unsigned RS_MSB  = 1;
  localparam int unsigned RS_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT
  } fetch_state_t;

  // Opcodes the control unit knows how to execute (HALT is handled locally).
  function automatic logic op_defined(input logic [3:0] op);
    return (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/instr_decode_fields.sv
// Splits an 8-bit instruction word into fields and flags HALT / undefined
// opcodes; undefined opcodes are replaced with NOP.
module instr_decode_fields
  import cpu_pkg::*;
(
  input  logic [7:0] instr,
  output logic [3:0] opcode,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic       is_halt,
  output logic       is_illegal
);

  logic [3:0] raw_op;

  always_comb begin
    raw_op     = instr[OPC_MSB:OPC_LSB];
    rd         = instr[RD_MSB:RD_LSB];
    rs         = instr[RS_MSB:RS_LSB];
    is_halt    = (raw_op == OP_HALT);
    is_illegal = !is_halt && !op_defined(raw_op);
    opcode     = is_illegal ? OP_NOP : raw_op;
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencer: fetches from program memory, issues decoded
// fields to the control unit, and tracks PC, HALT, illegal and retire count.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_rvalid,
  output logic [3:0]        Opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic              issue_valid,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instr_count
);

  fetch_state_t state, state_nxt;

  logic [3:0] dec_op;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic       dec_halt;
  logic       dec_ill;
  logic       go;
  logic       accept;
  logic       retire;

  instr_decode_fields u_dec (
    .instr      (imem_rdata),
    .opcode     (dec_op),
    .rd         (dec_rd),
    .rs         (dec_rs),
    .is_halt    (dec_halt),
    .is_illegal (dec_ill)
  );

  always_comb begin
    state_nxt   = state;
    go          = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    imem_req    = 1'b0;
    issue_valid = 1'b0;
    halted      = 1'b0;
    imem_addr   = pc;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          go        = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          accept    = 1'b1;
          state_nxt = dec_halt ? ST_HALT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_valid = 1'b1;
        if (!stall) begin
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) begin
          go        = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      Opcode      <= '0;
      rd          <= '0;
      rs          <= '0;
    end else begin
      state <= state_nxt;
      if (go)
        pc <= '0;
      else if (retire)
        pc <= pc + ADDR_W'(1);
      if (retire && (instr_count != '1))
        instr_count <= instr_count + CNT_W'(1);
      // HALT is consumed here, so it never overwrites the held fields.
      if (accept && !dec_halt) begin
        Opcode  <= dec_op;
        rd      <= dec_rd;
        rs      <= dec_rs;
        illegal <= illegal | dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: transaction-level reference model
// with per-cycle comparison, directed programs, random traffic and a tiny build.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [7:0]  imem_rdata = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [3:0]  Opcode;
  logic [1:0]  rd, rs;
  logic        issue_valid, halted, illegal;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  logic        s_start = 1'b0;
  logic        s_stall = 1'b0;
  logic        s_rvalid = 1'b0;
  logic [7:0]  s_rdata = 8'h00;
  logic        s_req, s_iv, s_halted, s_ill;
  logic [1:0]  s_addr, s_pc, s_cnt, s_rd, s_rs;
  logic [3:0]  s_op;

  instr_fetch_seq #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_rvalid(imem_rvalid), .Opcode(Opcode), .rd(rd), .rs(rs),
    .issue_valid(issue_valid), .halted(halted), .illegal(illegal),
    .pc(pc), .instr_count(instr_count)
  );

  instr_fetch_seq #(.ADDR_W(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stall(s_stall),
    .imem_req(s_req), .imem_addr(s_addr), .imem_rdata(s_rdata),
    .imem_rvalid(s_rvalid), .Opcode(s_op), .rd(s_rd), .rs(s_rs),
    .issue_valid(s_iv), .halted(s_halted), .illegal(s_ill),
    .pc(s_pc), .instr_count(s_cnt)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          cmp_en = 1'b0;

  // Reference model: what the sequencer is doing and what it holds.
  bit          m_waiting_mem, m_presenting, m_stopped, m_ill;
  int unsigned m_pc, m_cnt, wait_n;
  logic [3:0]  m_op;
  logic [1:0]  m_rd, m_rs;
  bit          rand_mode = 1'b0;
  logic [7:0]  mem [256];
  logic [3:0]  seen_op [16];
  logic [1:0]  seen_rd [16];
  logic [1:0]  seen_rs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_waiting_mem = 0; m_presenting = 0; m_stopped = 0; m_ill = 0;
    m_pc = 0; m_cnt = 0; wait_n = 0; m_op = '0; m_rd = '0; m_rs = '0;
    start = 0; stall = 0; imem_rvalid = 0;
  endtask

  // Called just after a falling edge: drive inputs, advance model to the
  // state the DUT must hold after the coming rising edge.
  task automatic tick(input bit st, input bit sl);
    logic [7:0] w;
    bit         rv;
    start = st;
    stall = sl;
    rv = rand_mode ? ($urandom_range(0, 2) != 0) : (m_waiting_mem && wait_n >= 1);
    w  = m_waiting_mem ? mem[m_pc[7:0]] : 8'($urandom);
    imem_rvalid = rv;
    imem_rdata  = w;
    if (m_waiting_mem) begin
      if (rv) begin
        m_waiting_mem = 0;
        wait_n = 0;
        if (w[7:4] == 4'hF) m_stopped = 1;
        else begin
          m_presenting = 1;
          m_op = (w[7:4] > 4'd8) ? 4'd0 : w[7:4];
          m_rd = w[3:2];
          m_rs = w[1:0];
          if (w[7:4] > 4'd8) m_ill = 1;
        end
      end else wait_n++;
    end else if (m_presenting) begin
      if (!sl) begin
        m_presenting = 0; m_waiting_mem = 1; wait_n = 0;
        m_pc = (m_pc + 1) % 256;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (st) begin
      m_waiting_mem = 1; m_stopped = 0; m_pc = 0; wait_n = 0;
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("imem_req", imem_req, m_waiting_mem);
      if (m_waiting_mem) chk("imem_addr", imem_addr, m_pc);
      chk("issue_valid", issue_valid, m_presenting);
      chk("halted", halted, m_stopped);
      chk("illegal", illegal, m_ill);
      chk("pc", pc, m_pc);
      chk("instr_count", instr_count, m_cnt);
      chk("Opcode", Opcode, m_op);
      chk("rd", rd, m_rd);
      chk("rs", rs, m_rs);
    end
  end

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input int unsigned budget, output int unsigned issues);
    issues = 0;
    tick(1, 0);
    for (int unsigned i = 0; i < budget && !m_stopped; i++) begin
      tick(0, 0);
      if (issue_valid && issues < 16) begin
        seen_op[issues] = Opcode; seen_rd[issues] = rd; seen_rs[issues] = rs;
        issues++;
      end
    end
    chk("halt_reached", halted, 1);
  endtask

  initial begin
    int unsigned n;
    logic [7:0] b;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [7:0] b;
    model_clear();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Basic ADD then HALT
    mem[0] = 8'h1B; mem[1] = 8'hF0;
    run_prog(20, n);
    chk("t1_issues", n, 1);
    chk("t1_op", seen_op[0], 4'h1);
    chk("t1_rd", seen_rd[0], 2);
    chk("t1_rs", seen_rs[0], 3);
    chk("t1_halted", halted, 1);
    chk("t1_pc", pc, 1);
    chk("t1_count", instr_count, 1);

    // Opcode sweep 0..8 then HALT
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      mem[i] = {4'(i), b[3:0]};
    end
    mem[9] = 8'hF5;
    run_prog(60, n);
    chk("t2_issues", n, 9);
    for (int i = 0; i < 9; i++) begin
      chk("t2_op", seen_op[i], i);
      b = mem[i];
      chk("t2_rd", seen_rd[i], b[3:2]);
      chk("t2_rs", seen_rs[i], b[1:0]);
    end
    chk("t2_count", instr_count, 9);
    chk("t2_illegal", illegal, 0);
    chk("t2_pc", pc, 9);

    // Undefined opcode issued as NOP, illegal sticky
    do_reset();
    mem[0] = 8'h9C; mem[1] = 8'h1B; mem[2] = 8'hF0;
    run_prog(30, n);
    chk("t3_op", seen_op[0], 0);
    chk("t3_rd", seen_rd[0], 3);
    chk("t3_rs", seen_rs[0], 0);
    chk("t3_op2", seen_op[1], 1);
    chk("t3_illegal", illegal, 1);
    chk("t3_count", instr_count, 2);

    // Stall hold during ISSUE
    do_reset();
    mem[0] = 8'h25; mem[1] = 8'hF0;
    tick(1, 0);
    for (int i = 0; i < 10 && !issue_valid; i++) tick(0, 0);
    n = issue_valid ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1);
      if (issue_valid && Opcode == 4'h2 && rd == 2'd1 && rs == 2'd1) n++;
      chk("t4_pc_hold", pc, 0);
      chk("t4_cnt_hold", instr_count, 0);
    end
    chk("t4_issue_cycles", n, 6);
    tick(0, 0);
    chk("t4_pc", pc, 1);
    chk("t4_count", instr_count, 1);
    chk("t4_iv_drop", issue_valid, 0);
    for (int i = 0; i < 10 && !m_stopped; i++) tick(0, 0);
    chk("t4_halted", halted, 1);

    // Random traffic: random memory, rvalid, stall and start
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    rand_mode = 1'b0;

    // Async reset in the middle of FETCH, then restart from pc 0
    mem[0] = 8'h1B; mem[1] = 8'hF0;
    do_reset();
    tick(1, 0);
    chk("t6_req_before", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async", imem_req, 0);
    chk("t6_pc_async", pc, 0);
    chk("t6_iv_async", issue_valid, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_prog(20, n);
    chk("t6_restart_pc", pc, 1);
    chk("t6_restart_cnt", instr_count, 1);

    // Narrow build: pc wraps 3->0, counter saturates at 3
    s_start = 1'b1;
    tick(0, 0);
    s_start = 1'b0;
    s_rvalid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(0, 0);
      chk("s_issue", s_iv, 1);
      chk("s_rd", s_rd, 0);
      tick(0, 0);
      chk("s_req", s_req, 1);
      chk("s_pc", s_pc, k % 4);
      chk("s_addr", s_addr, k % 4);
      chk("s_cnt", s_cnt, (k > 3) ? 3 : k);
    end
    chk("s_halted", s_halted, 0);
    chk("s_illegal", s_ill, 0);
    chk("s_op", s_op, 0);
    chk("s_rs", s_rs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
